// File: rtl/da_fir_core.sv
// Bit-serial distributed-arithmetic FIR engine: delay line, LSB-first ROM slice addressing, shift-add accumulate.
// Optional DA_FIR_CLR_EN adds a synchronous delay-line flush input (clr), honoured only in IDLE.
module da_fir_core #(
  parameter  int unsigned N_TAPS = 5,
  parameter  int unsigned DATA_W = 16,
  parameter  int unsigned ROM_W  = 18,
  localparam int unsigned ACC_W  = DATA_W + ROM_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef DA_FIR_CLR_EN
  input  logic              clr,
`endif
  input  logic              din_valid,
  output logic              din_ready,
  input  logic [DATA_W-1:0] din,
  output logic [N_TAPS-1:0] rom_addr,
  input  logic [ROM_W-1:0]  rom_data,
  output logic              dout_valid,
  output logic [ACC_W-1:0]  dout
);

  localparam int unsigned CNT_W = $clog2(DATA_W);

  typedef enum logic {IDLE = 1'b0, CALC = 1'b1} state_e;

  state_e                   state_q, state_d;
  logic [DATA_W-1:0]        taps_q [N_TAPS];
  logic [DATA_W-1:0]        taps_d [N_TAPS];
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [ACC_W-1:0]  dout_q, dout_d;
  logic                     dout_valid_q, dout_valid_d;
  logic [N_TAPS-1:0]        rom_addr_q, rom_addr_d;
  logic signed [ACC_W-1:0]  term;
  logic                     clr_c;
  logic                     accept_c;
  logic                     last_c;

`ifdef DA_FIR_CLR_EN
  assign clr_c = clr;
`else
  assign clr_c = 1'b0;
`endif

  // A flush request in IDLE blocks the handshake for that cycle.
  assign din_ready = (state_q == IDLE) && !clr_c;
  assign accept_c  = din_valid && din_ready;
  assign last_c    = (cnt_q == CNT_W'(DATA_W - 1));

  assign rom_addr   = rom_addr_q;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;

  always_comb begin
    state_d      = state_q;
    taps_d       = taps_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    rom_addr_d   = '0;
    term         = ACC_W'($signed(rom_data)) <<< cnt_q;

    case (state_q)
      IDLE: begin
        if (clr_c) begin
          for (int unsigned i = 0; i < N_TAPS; i++) taps_d[i] = '0;
        end else if (accept_c) begin
          taps_d[0] = din;
          for (int unsigned i = 1; i < N_TAPS; i++) taps_d[i] = taps_q[i-1];
          acc_d   = '0;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        // The sign-bit slice carries negative weight.
        if (last_c) begin
          acc_d        = acc_q - term;
          dout_d       = acc_d;
          dout_valid_d = 1'b1;
          cnt_d        = '0;
          state_d      = IDLE;
        end else begin
          acc_d = acc_q + term;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Present the slice for the bit position that the next cycle consumes.
    for (int unsigned i = 0; i < N_TAPS; i++) begin
      rom_addr_d[i] = (state_d == CALC) ? taps_d[i][cnt_d] : 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      for (int unsigned i = 0; i < N_TAPS; i++) taps_q[i] <= '0;
      cnt_q        <= '0;
      acc_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      rom_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      taps_q       <= taps_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      rom_addr_q   <= rom_addr_d;
    end
  end

endmodule

// File: tb/tb_da_fir_core.sv
// Scoreboard bench for da_fir_core with a linear DA ROM model h = {1,2,3,4,5}; expected outputs are hand-computed.
module tb_da_fir_core;

  localparam int unsigned N_TAPS = 5;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned ROM_W  = 18;
  localparam int unsigned ACC_W  = DATA_W + ROM_W + 1;

  logic              clk;
  logic              rst_n;
  logic              din_valid;
  logic              din_ready;
  logic [DATA_W-1:0] din;
  logic [N_TAPS-1:0] rom_addr;
  logic [ROM_W-1:0]  rom_data;
  logic              dout_valid;
  logic [ACC_W-1:0]  dout;
`ifdef DA_FIR_CLR_EN
  logic              clr;
`endif

  int     checks   = 0;
  int     failures = 0;
  longint exp_q[$];
  longint last_exp = 0;
  int     h[N_TAPS] = '{1, 2, 3, 4, 5};
  int     rom_sum;

  da_fir_core dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef DA_FIR_CLR_EN
    .clr       (clr),
`endif
    .din_valid (din_valid),
    .din_ready (din_ready),
    .din       (din),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .dout_valid(dout_valid),
    .dout      (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Linear DA ROM: word = sum of h_i over set address bits.
  always_comb begin
    rom_sum = 0;
    for (int i = 0; i < N_TAPS; i++) if (rom_addr[i]) rom_sum += h[i];
    rom_data = ROM_W'(rom_sum);
  end

  task automatic chk(input string name, input longint act, input longint exp_v);
    checks++;
    if (act != exp_v) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  // Monitor: every output pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (dout_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_dout_valid: got dout=%0d expected no pulse", longint'($signed(dout)));
      end else begin
        longint e;
        e = exp_q.pop_front();
        last_exp = e;
        chk("dout", longint'($signed(dout)), e);
      end
    end
  end

  task automatic send(input logic [DATA_W-1:0] v, input longint exp_v, input bit b2b);
    int waits;
    waits = 0;
    din = v;
    din_valid = 1'b1;
    @(negedge clk);
    while (!din_ready && waits < 100) begin
      waits++;
      @(negedge clk);
    end
    if (!din_ready) begin
      chk("accept_timeout", 0, 1);
    end else begin
      if (b2b) begin
        chk("busy_cycles", waits, 16);
        chk("dout_valid_with_accept", longint'(dout_valid), 1);
      end
      exp_q.push_back(exp_v);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    din_valid = 1'b0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("drain_pending", exp_q.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    din_valid = 1'b0;
    din = '0;
`ifdef DA_FIR_CLR_EN
    clr = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dout", longint'($signed(dout)), 0);
    chk("rst_dout_valid", longint'(dout_valid), 0);
    chk("rst_rom_addr", longint'(rom_addr), 0);
    chk("rst_din_ready", longint'(din_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Impulse, then check the first slice address.
    send(16'd1, 1, 1'b0);
    chk("rom_addr_slice0", longint'(rom_addr), 1);
    send(16'd0, 2, 1'b1);
    send(16'd0, 3, 1'b1);
    send(16'd0, 4, 1'b1);
    send(16'd0, 5, 1'b1);
    send(16'd0, 0, 1'b1);

    // Negative impulse.
    send(16'hFFFF, -1, 1'b1);
    send(16'd0, -2, 1'b1);
    send(16'd0, -3, 1'b1);
    send(16'd0, -4, 1'b1);
    send(16'd0, -5, 1'b1);
    send(16'd0, 0, 1'b1);

    // Full-scale negative samples.
    send(16'h8000, -32768, 1'b1);
    send(16'h8000, -98304, 1'b1);
    send(16'h8000, -196608, 1'b1);
    send(16'h8000, -327680, 1'b1);
    send(16'h8000, -491520, 1'b1);
    send(16'h8000, -491520, 1'b1);
    drain();

    // Reset at cnt=7 aborts the computation.
    send(16'd3, 0, 1'b0);
    din_valid = 1'b0;
    void'(exp_q.pop_back());
    repeat (7) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_dout", longint'($signed(dout)), 0);
    chk("midrst_dout_valid", longint'(dout_valid), 0);
    chk("midrst_rom_addr", longint'(rom_addr), 0);
    chk("midrst_din_ready", longint'(din_ready), 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    send(16'd1, 1, 1'b0);
    drain();

    // Continuous valid: taps start as {1,0,0,0,0}.
    send(16'd2, 4, 1'b0);
    send(16'hFFFD, 4, 1'b1);
    send(16'd100, 104, 1'b1);
    send(16'd0, 204, 1'b1);
    send(16'd0, 298, 1'b1);
    send(16'd0, 385, 1'b1);
    send(16'd0, 500, 1'b1);
    send(16'd0, 0, 1'b1);
    drain();

`ifdef DA_FIR_CLR_EN
    send(16'd3, 3, 1'b0);
    send(16'd3, 9, 1'b1);
    drain();
    clr = 1'b1;
    #1;
    chk("clr_blocks_ready", longint'(din_ready), 0);
    @(posedge clk);
    #1;
    clr = 1'b0;
    send(16'd1, 1, 1'b0);
    drain();
    send(16'd5, 7, 1'b0);
    din_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    drain();
`endif

    repeat (5) @(posedge clk);
    #1;
    chk("dout_hold", longint'($signed(dout)), last_exp);
    chk("dout_valid_idle", longint'(dout_valid), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
